// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle MIPS-style datapath: fetch/decode/execute/memory/writeback
// sequencing with memory-wait timeout and sticky illegal/timeout error flags.
module multicycle_ctrl #(
   parameter int unsigned WAIT_LIMIT = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   input  logic       eq,
   output logic [2:0] alu_op,
   output logic       ir_write,
   output logic       pc_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       iord,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_out_write,
   output logic [1:0] pc_src,
   output logic [1:0] alu_src_b,
   output logic [2:0] state,
   output logic       instr_done,
   output logic       illegal,
   output logic       timeout
);

   localparam int unsigned CntW =
      ($clog2(WAIT_LIMIT + 1) > 4) ? $clog2(WAIT_LIMIT + 1) : 4;

   localparam logic [5:0] OpRtype = 6'h00;
   localparam logic [5:0] OpLw    = 6'h23;
   localparam logic [5:0] OpSw    = 6'h2B;
   localparam logic [5:0] OpBeq   = 6'h04;
   localparam logic [5:0] OpJ     = 6'h02;
   localparam logic [5:0] OpAddi  = 6'h08;
   localparam logic [5:0] OpAndi  = 6'h0C;
   localparam logic [5:0] OpOri   = 6'h0D;

   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StMem    = 3'd3,
      StWb     = 3'd4,
      StErr    = 3'd7
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            illegal_q, timeout_q;
   logic            set_illegal, set_timeout;
   logic            is_r, is_lw, is_sw, is_beq, is_j, is_addi, is_andi, is_ori, legal;
   logic            in_wait_state, wait_exp;
   logic [2:0]      dec_alu_op;

   assign is_r    = (opcode == OpRtype);
   assign is_lw   = (opcode == OpLw);
   assign is_sw   = (opcode == OpSw);
   assign is_beq  = (opcode == OpBeq);
   assign is_j    = (opcode == OpJ);
   assign is_addi = (opcode == OpAddi);
   assign is_andi = (opcode == OpAndi);
   assign is_ori  = (opcode == OpOri);
   assign legal   = is_r | is_lw | is_sw | is_beq | is_j | is_addi | is_andi | is_ori;

   // Pure function of opcode, so it holds steady from DECODE through EXEC.
   always_comb begin
      dec_alu_op = 3'd1;
      if (is_r)         dec_alu_op = 3'd0;
      else if (is_andi) dec_alu_op = 3'd2;
      else if (is_ori)  dec_alu_op = 3'd3;
   end

   assign in_wait_state = (state_q == StFetch) || (state_q == StMem);
   assign wait_exp      = in_wait_state && !mem_ready && (cnt_q == CntW'(WAIT_LIMIT));

   always_comb begin
      state_d       = state_q;
      set_illegal   = 1'b0;
      set_timeout   = 1'b0;
      alu_op        = 3'd1;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      iord          = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      alu_out_write = 1'b0;
      pc_src        = 2'd0;
      alu_src_b     = 2'd0;
      instr_done    = 1'b0;
      unique case (state_q)
         StFetch: begin
            if (wait_exp) begin
               set_timeout = 1'b1;
               state_d     = StErr;
            end else begin
               mem_read = 1'b1;
               if (mem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
                  state_d  = StDecode;
               end
            end
         end
         StDecode: begin
            alu_op = dec_alu_op;
            if (is_j) begin
               pc_write   = 1'b1;
               pc_src     = 2'd2;
               instr_done = 1'b1;
               state_d    = StFetch;
            end else if (!legal) begin
               set_illegal = 1'b1;
               state_d     = StErr;
            end else begin
               state_d = StExec;
            end
         end
         StExec: begin
            alu_op = dec_alu_op;
            if (is_lw || is_sw || is_addi) alu_src_b = 2'd1;
            else if (is_andi || is_ori)    alu_src_b = 2'd2;
            if (is_beq) begin
               pc_write   = eq;
               pc_src     = 2'd1;
               instr_done = 1'b1;
               state_d    = StFetch;
            end else begin
               alu_out_write = 1'b1;
               state_d       = (is_lw || is_sw) ? StMem : StWb;
            end
         end
         StMem: begin
            alu_op = dec_alu_op;
            if (wait_exp) begin
               set_timeout = 1'b1;
               state_d     = StErr;
            end else begin
               iord      = 1'b1;
               mem_read  = is_lw;
               mem_write = is_sw;
               if (mem_ready) begin
                  if (is_lw) begin
                     state_d = StWb;
                  end else begin
                     instr_done = 1'b1;
                     state_d    = StFetch;
                  end
               end
            end
         end
         StWb: begin
            alu_op     = dec_alu_op;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            reg_dst    = is_r;
            mem_to_reg = is_lw;
            state_d    = StFetch;
         end
         StErr: state_d = StErr;
         default: state_d = StErr;
      endcase

      // Reset masks every strobe immediately, not just after the next edge.
      if (!rst_n) begin
         alu_op        = 3'd1;
         ir_write      = 1'b0;
         pc_write      = 1'b0;
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         iord          = 1'b0;
         reg_write     = 1'b0;
         reg_dst       = 1'b0;
         mem_to_reg    = 1'b0;
         alu_out_write = 1'b0;
         pc_src        = 2'd0;
         alu_src_b     = 2'd0;
         instr_done    = 1'b0;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q || mem_ready) cnt_d = '0;
      else if (in_wait_state)              cnt_d = cnt_q + CntW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StFetch;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_q | set_illegal;
         timeout_q <= timeout_q | set_timeout;
      end
   end

   assign state   = state_q;
   assign illegal = illegal_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: inputs change on the falling edge, outputs are
// checked 1 ns later against hand-derived per-cycle expectations.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic       mem_ready, eq;
   logic [2:0] alu_op, state;
   logic       ir_write, pc_write, mem_read, mem_write, iord, reg_write, reg_dst;
   logic       mem_to_reg, alu_out_write, instr_done, illegal, timeout;
   logic [1:0] pc_src, alu_src_b;

   int checks = 0;
   int failures = 0;

   localparam logic [9:0] IRW = 10'h200;
   localparam logic [9:0] PCW = 10'h100;
   localparam logic [9:0] MRD = 10'h080;
   localparam logic [9:0] MWR = 10'h040;
   localparam logic [9:0] IOD = 10'h020;
   localparam logic [9:0] RGW = 10'h010;
   localparam logic [9:0] RDS = 10'h008;
   localparam logic [9:0] MTR = 10'h004;
   localparam logic [9:0] AOW = 10'h002;
   localparam logic [9:0] DON = 10'h001;
   localparam logic [9:0] NONE = 10'h000;

   logic [9:0] strb;
   assign strb = {ir_write, pc_write, mem_read, mem_write, iord,
                  reg_write, reg_dst, mem_to_reg, alu_out_write, instr_done};

   multicycle_ctrl #(.WAIT_LIMIT(15)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .eq            (eq),
      .alu_op        (alu_op),
      .ir_write      (ir_write),
      .pc_write      (pc_write),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .iord          (iord),
      .reg_write     (reg_write),
      .reg_dst       (reg_dst),
      .mem_to_reg    (mem_to_reg),
      .alu_out_write (alu_out_write),
      .pc_src        (pc_src),
      .alu_src_b     (alu_src_b),
      .state         (state),
      .instr_done    (instr_done),
      .illegal       (illegal),
      .timeout       (timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic drive(input logic r, input logic [5:0] op, input logic mr, input logic e);
      @(negedge clk);
      rst_n     = r;
      opcode    = op;
      mem_ready = mr;
      eq        = e;
      #1;
   endtask

   task automatic expect_cyc(input string tag, input logic [2:0] st, input logic [2:0] aop,
                             input logic [1:0] ps, input logic [1:0] asb,
                             input logic [9:0] s);
      chk({tag, ".state"}, {7'd0, state}, {7'd0, st});
      chk({tag, ".alu_op"}, {7'd0, alu_op}, {7'd0, aop});
      chk({tag, ".pc_src"}, {8'd0, pc_src}, {8'd0, ps});
      chk({tag, ".alu_src_b"}, {8'd0, alu_src_b}, {8'd0, asb});
      chk({tag, ".strobes"}, strb, s);
   endtask

   task automatic flags(input string tag, input logic ill, input logic tmo);
      chk({tag, ".illegal"}, {9'd0, illegal}, {9'd0, ill});
      chk({tag, ".timeout"}, {9'd0, timeout}, {9'd0, tmo});
   endtask

   task automatic fetch_ok(input string tag, input logic [5:0] op);
      drive(1'b1, op, 1'b1, 1'b0);
      expect_cyc(tag, 3'd0, 3'd1, 2'd0, 2'd0, IRW | PCW | MRD);
   endtask

   initial begin
      rst_n = 1'b0; opcode = 6'h00; mem_ready = 1'b0; eq = 1'b0;

      // Reset state
      drive(1'b0, 6'h00, 1'b0, 1'b0);
      expect_cyc("rst", 3'd0, 3'd1, 2'd0, 2'd0, NONE);
      flags("rst", 1'b0, 1'b0);

      // R-type: 0,1,2,4
      fetch_ok("r_f", 6'h00);
      drive(1'b1, 6'h00, 1'b1, 1'b0); expect_cyc("r_d", 3'd1, 3'd0, 2'd0, 2'd0, NONE);
      drive(1'b1, 6'h00, 1'b1, 1'b0); expect_cyc("r_e", 3'd2, 3'd0, 2'd0, 2'd0, AOW);
      drive(1'b1, 6'h00, 1'b1, 1'b0); expect_cyc("r_w", 3'd4, 3'd0, 2'd0, 2'd0, RGW | RDS | DON);

      // lw with three wait cycles in MEM
      fetch_ok("lw_f", 6'h23);
      drive(1'b1, 6'h23, 1'b1, 1'b0); expect_cyc("lw_d", 3'd1, 3'd1, 2'd0, 2'd0, NONE);
      drive(1'b1, 6'h23, 1'b1, 1'b0); expect_cyc("lw_e", 3'd2, 3'd1, 2'd0, 2'd1, AOW);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 6'h23, 1'b0, 1'b0);
         expect_cyc("lw_mwait", 3'd3, 3'd1, 2'd0, 2'd0, MRD | IOD);
      end
      drive(1'b1, 6'h23, 1'b1, 1'b0); expect_cyc("lw_m", 3'd3, 3'd1, 2'd0, 2'd0, MRD | IOD);
      drive(1'b1, 6'h23, 1'b1, 1'b0); expect_cyc("lw_w", 3'd4, 3'd1, 2'd0, 2'd0, RGW | MTR | DON);

      // beq taken, then not taken
      fetch_ok("beq1_f", 6'h04);
      drive(1'b1, 6'h04, 1'b1, 1'b1); expect_cyc("beq1_d", 3'd1, 3'd1, 2'd0, 2'd0, NONE);
      drive(1'b1, 6'h04, 1'b1, 1'b1); expect_cyc("beq1_e", 3'd2, 3'd1, 2'd1, 2'd0, PCW | DON);
      fetch_ok("beq0_f", 6'h04);
      drive(1'b1, 6'h04, 1'b1, 1'b0); expect_cyc("beq0_d", 3'd1, 3'd1, 2'd0, 2'd0, NONE);
      drive(1'b1, 6'h04, 1'b1, 1'b0); expect_cyc("beq0_e", 3'd2, 3'd1, 2'd1, 2'd0, DON);

      // ori then andi
      fetch_ok("ori_f", 6'h0D);
      drive(1'b1, 6'h0D, 1'b1, 1'b0); expect_cyc("ori_d", 3'd1, 3'd3, 2'd0, 2'd0, NONE);
      drive(1'b1, 6'h0D, 1'b1, 1'b0); expect_cyc("ori_e", 3'd2, 3'd3, 2'd0, 2'd2, AOW);
      drive(1'b1, 6'h0D, 1'b1, 1'b0); expect_cyc("ori_w", 3'd4, 3'd3, 2'd0, 2'd0, RGW | DON);
      fetch_ok("andi_f", 6'h0C);
      drive(1'b1, 6'h0C, 1'b1, 1'b0); expect_cyc("andi_d", 3'd1, 3'd2, 2'd0, 2'd0, NONE);
      drive(1'b1, 6'h0C, 1'b1, 1'b0); expect_cyc("andi_e", 3'd2, 3'd2, 2'd0, 2'd2, AOW);
      drive(1'b1, 6'h0C, 1'b1, 1'b0); expect_cyc("andi_w", 3'd4, 3'd2, 2'd0, 2'd0, RGW | DON);

      // sw, then addi, then j
      fetch_ok("sw_f", 6'h2B);
      drive(1'b1, 6'h2B, 1'b1, 1'b0); expect_cyc("sw_d", 3'd1, 3'd1, 2'd0, 2'd0, NONE);
      drive(1'b1, 6'h2B, 1'b1, 1'b0); expect_cyc("sw_e", 3'd2, 3'd1, 2'd0, 2'd1, AOW);
      drive(1'b1, 6'h2B, 1'b1, 1'b0); expect_cyc("sw_m", 3'd3, 3'd1, 2'd0, 2'd0, MWR | IOD | DON);
      fetch_ok("addi_f", 6'h08);
      drive(1'b1, 6'h08, 1'b1, 1'b0); expect_cyc("addi_d", 3'd1, 3'd1, 2'd0, 2'd0, NONE);
      drive(1'b1, 6'h08, 1'b1, 1'b0); expect_cyc("addi_e", 3'd2, 3'd1, 2'd0, 2'd1, AOW);
      drive(1'b1, 6'h08, 1'b1, 1'b0); expect_cyc("addi_w", 3'd4, 3'd1, 2'd0, 2'd0, RGW | DON);
      fetch_ok("j_f", 6'h02);
      drive(1'b1, 6'h02, 1'b1, 1'b0); expect_cyc("j_d", 3'd1, 3'd1, 2'd2, 2'd0, PCW | DON);

      // Fetch completes on exactly the limit cycle: no timeout
      for (int i = 0; i < 15; i++) begin
         drive(1'b1, 6'h02, 1'b0, 1'b0);
         expect_cyc("lim_wait", 3'd0, 3'd1, 2'd0, 2'd0, MRD);
      end
      fetch_ok("lim_f", 6'h02);
      drive(1'b1, 6'h02, 1'b1, 1'b0); expect_cyc("lim_d", 3'd1, 3'd1, 2'd2, 2'd0, PCW | DON);
      flags("lim", 1'b0, 1'b0);

      // Fetch timeout on the 16th stalled cycle
      for (int i = 0; i < 15; i++) begin
         drive(1'b1, 6'h00, 1'b0, 1'b0);
         expect_cyc("tmo_wait", 3'd0, 3'd1, 2'd0, 2'd0, MRD);
      end
      drive(1'b1, 6'h00, 1'b0, 1'b0); expect_cyc("tmo_hit", 3'd0, 3'd1, 2'd0, 2'd0, NONE);
      flags("tmo_hit", 1'b0, 1'b0);
      drive(1'b1, 6'h00, 1'b1, 1'b0); expect_cyc("tmo_err", 3'd7, 3'd1, 2'd0, 2'd0, NONE);
      flags("tmo_err", 1'b0, 1'b1);
      drive(1'b0, 6'h00, 1'b1, 1'b0); expect_cyc("tmo_rst", 3'd7, 3'd1, 2'd0, 2'd0, NONE);
      fetch_ok("tmo_after", 6'h3F);
      flags("tmo_after", 1'b0, 1'b0);

      // Illegal opcode, ERR held 10 cycles, then reset
      drive(1'b1, 6'h3F, 1'b1, 1'b0); expect_cyc("ill_d", 3'd1, 3'd1, 2'd0, 2'd0, NONE);
      flags("ill_d", 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 6'h3F, 1'b1, 1'b1);
         expect_cyc("ill_err", 3'd7, 3'd1, 2'd0, 2'd0, NONE);
         flags("ill_err", 1'b1, 1'b0);
      end
      drive(1'b0, 6'h3F, 1'b1, 1'b0); expect_cyc("ill_rst", 3'd7, 3'd1, 2'd0, 2'd0, NONE);
      fetch_ok("ill_after", 6'h23);
      flags("ill_after", 1'b0, 1'b0);

      // Reset mid-MEM of a stalled lw
      drive(1'b1, 6'h23, 1'b1, 1'b0); expect_cyc("mr_d", 3'd1, 3'd1, 2'd0, 2'd0, NONE);
      drive(1'b1, 6'h23, 1'b1, 1'b0); expect_cyc("mr_e", 3'd2, 3'd1, 2'd0, 2'd1, AOW);
      drive(1'b1, 6'h23, 1'b0, 1'b0); expect_cyc("mr_m", 3'd3, 3'd1, 2'd0, 2'd0, MRD | IOD);
      drive(1'b0, 6'h23, 1'b0, 1'b0); expect_cyc("mr_rst", 3'd3, 3'd1, 2'd0, 2'd0, NONE);
      fetch_ok("mr_after", 6'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: WAIT_LIMIT, default 15, number of consecutive mem_ready-low cycles tolerated in FETCH or MEM before timeout.
REQ-002 The block SHALL use one clock and a synchronous, active-low reset.
REQ-003 Port clk, input, 1 bit: rising-edge clock.
REQ-004 Port rst_n, input, 1 bit: synchronous active-low reset.
REQ-005 Port opcode, input, 6 bits: IR[31:26]; valid from DECODE onward.
REQ-006 Port mem_ready, input, 1 bit: memory access completes this cycle.
REQ-007 Port eq, input, 1 bit: register-equality comparator result; valid in EXEC.
REQ-008 Port alu_op, output, 3 bits: to ALU control. Encoding: 0 R-type (funct), 1 add, 2 and, 3 or.
REQ-009 Port ir_write, pc_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, alu_out_write, outputs, 1 bit each: datapath strobes/selects.
REQ-010 Port pc_src, output, 2 bits: 0 PC+4, 1 branch target, 2 jump target.
REQ-011 Port alu_src_b, output, 2 bits: 0 register rt, 1 sign-extended imm, 2 zero-extended imm.
REQ-012 Port state, output, 3 bits: current state, for debug.
REQ-013 Port instr_done, output, 1 bit: one-cycle pulse on the last cycle of each instruction.
REQ-014 Port illegal and timeout, outputs, 1 bit each: sticky error flags.

Function
REQ-015 States SHALL be: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=7. All outputs not listed for a state SHALL be 0.
REQ-016 FETCH: mem_read=1, iord=0. When mem_ready=1, drive ir_write=1, pc_write=1, pc_src=0, and go to DECODE. Otherwise stay in FETCH.
REQ-017 DECODE: recognized opcodes are 0x00, 0x23 lw, 0x2B sw, 0x04 beq, 0x02 j, 0x08 addi, 0x0C andi, 0x0D ori.
REQ-018 DECODE with j: pc_write=1, pc_src=2, instr_done=1, then FETCH.
REQ-019 DECODE with an unrecognized opcode: illegal is set and the FSM goes to ERR.
REQ-020 DECODE with any other recognized opcode: go to EXEC.
REQ-021 alu_op SHALL be decoded combinationally from opcode in DECODE, EXEC, MEM and WB: R-type 0; lw, sw, addi, beq, j 1; andi 2; ori 3. In FETCH and ERR, alu_op SHALL be 1.
REQ-022 Because the downstream ALU control registers alu_op, alu_op SHALL be stable from the first DECODE cycle through the last EXEC cycle.
REQ-023 EXEC: alu_src_b is 0 for R-type and beq, 1 for lw, sw and addi, and 2 for andi and ori. alu_out_write=1 except for beq.
REQ-024 EXEC next state: lw and sw go to MEM. R-type and immediate ALU ops go to WB.
REQ-025 EXEC with beq: pc_write=eq, pc_src=1, instr_done=1, then FETCH.
REQ-026 MEM: iord=1. lw drives mem_read=1; sw drives mem_write=1. Stay in MEM until mem_ready=1. Then lw goes to WB; sw asserts instr_done=1 and goes to FETCH.
REQ-027 WB: reg_write=1 and instr_done=1, then FETCH. reg_dst=1 only for R-type. mem_to_reg=1 only for lw.
REQ-028 Wait counter: 4 bits minimum. Increments each FETCH or MEM cycle with mem_ready=0. Clears on mem_ready=1 and on any state change.
REQ-029 When the wait counter equals WAIT_LIMIT and mem_ready=0, timeout is set and the FSM goes to ERR. No strobe is asserted in that cycle.
REQ-030 If mem_ready=1 in the same cycle the count reaches WAIT_LIMIT, the access completes normally with no timeout.
REQ-031 ERR is absorbing: all strobes are 0, alu_op=1, and only reset exits.
REQ-032 Cycle counts with mem_ready always 1: j 2, beq 3, sw 4, R-type and immediate ALU ops 4, lw 5.

Reset
REQ-033 When rst_n=0 at a clock edge: state=FETCH, wait counter=0, illegal=0, timeout=0, instr_done=0. This SHALL take priority over all other conditions, including in ERR and mid-MEM.
REQ-034 While in reset, all strobe outputs SHALL be 0 and alu_op SHALL be 1. The FSM SHALL restart at FETCH on the first clock edge with rst_n=1.

Verification
REQ-035 Scenario: R-type 0x00, mem_ready=1 -> states 0,1,2,4,0; alu_op=0 in DECODE and EXEC; reg_dst=1, reg_write=1 in WB; instr_done once.
REQ-036 Scenario: lw 0x23 with mem_ready low 3 cycles in MEM -> MEM held 4 cycles with mem_read=1, iord=1; then WB with mem_to_reg=1; 8 cycles total.
REQ-037 Scenario: beq 0x04 with eq=1, then eq=0 -> pc_write=1, pc_src=1 in EXEC for the first; pc_write=0 for the second; each takes 3 cycles.
REQ-038 Scenario: opcode 0x3F -> ERR after DECODE; illegal=1 held 10 cycles; rst_n=0 for one edge -> state=0, illegal=0.
REQ-039 Scenario: mem_ready held 0 in FETCH, WAIT_LIMIT=15 -> 15 wait cycles, then on the 16th FETCH cycle timeout=1 and ERR; a variant with mem_ready=1 on exactly that cycle -> DECODE, no timeout.
REQ-040 Scenario: ori 0x0D then andi 0x0C back-to-back -> alu_op=3 then 2; alu_src_b=2; each takes 4 cycles.
